// File: rtl/key_pkg.sv
// Shared definitions for the key input path: debounce FSM states and default timing.
package key_pkg;

    typedef enum logic [1:0] {
        StIdle       = 2'd0,
        StPressDly   = 2'd1,
        StHeld       = 2'd2,
        StReleaseDly = 2'd3
    } key_state_e;

    // 50 MHz clock: cycles per millisecond minus one.
    localparam int unsigned T1MS_DEFAULT = 49_999;

    localparam int unsigned MS_CNT_W = 10;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond prescaler with a registered tick; clr_i restarts the count so that
// every delay begins phase-aligned.
module ms_tick_gen
    import key_pkg::*;
#(
    parameter int unsigned T1MS = T1MS_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic ms_tick_o
);

    localparam int unsigned CntW = (T1MS > 0) ? $clog2(T1MS + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(T1MS);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            tick_q, tick_d;

    always_comb begin
        cnt_d  = cnt_q + CntW'(1);
        tick_d = 1'b0;
        if (clr_i) begin
            cnt_d  = '0;
        end else if (cnt_q == CntLast) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign ms_tick_o = tick_q;

endmodule

// File: rtl/key_debounce_fsm.sv
// Key debouncer: turns edge strobes into a clean level plus press, release and
// long-press pulses, with a millisecond lockout after each accepted edge.
module key_debounce_fsm
    import key_pkg::*;
#(
    parameter int unsigned T1MS        = T1MS_DEFAULT,
    parameter int unsigned DEBOUNCE_MS = 10,
    parameter int unsigned LONG_MS     = 1000
) (
    input  logic CLK,
    input  logic RST,
    input  logic H2L_Sig,
    input  logic L2H_Sig,
    output logic Pin_Out,
    output logic Press_Pulse,
    output logic Release_Pulse,
    output logic Long_Pulse
);

    localparam logic [MS_CNT_W-1:0] DebLast = MS_CNT_W'(DEBOUNCE_MS - 1);
    localparam logic [MS_CNT_W-1:0] LongLast = MS_CNT_W'(LONG_MS - 1);
    localparam logic [MS_CNT_W-1:0] LongSat = MS_CNT_W'(LONG_MS);

    key_state_e          state_q, state_d;
    logic [MS_CNT_W-1:0] ms_q, ms_d;
    logic                long_done_q, long_done_d;
    logic                pin_q, pin_d;
    logic                press_q, press_d;
    logic                release_q, release_d;
    logic                long_q, long_d;

    logic ms_tick;
    logic state_chg;
    logic dly_done;
    logic long_hit;

    ms_tick_gen #(
        .T1MS (T1MS)
    ) u_ms_tick_gen (
        .clk_i     (CLK),
        .rst_i     (RST),
        .clr_i     (state_chg),
        .ms_tick_o (ms_tick)
    );

    assign dly_done = ms_tick && (ms_q == DebLast);
    assign long_hit = ms_tick && (ms_q == LongLast) && !long_done_q;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; strobes outside IDLE/HELD are dropped (lockout)
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:       if (H2L_Sig)  state_d = StPressDly;
            StPressDly:   if (dly_done) state_d = StHeld;
            StHeld:       if (L2H_Sig)  state_d = StReleaseDly;
            StReleaseDly: if (dly_done) state_d = StIdle;
            default:                    state_d = StIdle;
        endcase
    end

    assign state_chg = (state_d != state_q);

    // ms counter: idle holds at zero, HELD saturates so it can never wrap
    always_comb begin
        ms_d = ms_q;
        if (state_chg) begin
            ms_d = '0;
        end else if (ms_tick && (state_q != StIdle)) begin
            if (!((state_q == StHeld) && (ms_q == LongSat))) begin
                ms_d = ms_q + MS_CNT_W'(1);
            end
        end
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        pin_d       = pin_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        long_done_d = long_done_q;
        unique case (state_q)
            StIdle: begin
                long_done_d = 1'b0;
            end
            StPressDly: begin
                if (dly_done) begin
                    pin_d   = 1'b0;
                    press_d = 1'b1;
                end
            end
            StHeld: begin
                if (long_hit) begin
                    long_d      = 1'b1;
                    long_done_d = 1'b1;
                end
                if (L2H_Sig) begin
                    long_done_d = 1'b0;
                end
            end
            StReleaseDly: begin
                if (dly_done) begin
                    pin_d     = 1'b1;
                    release_d = 1'b1;
                end
            end
            default: begin
                pin_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ms_q        <= '0;
            long_done_q <= 1'b0;
            pin_q       <= 1'b1;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
        end else begin
            ms_q        <= ms_d;
            long_done_q <= long_done_d;
            pin_q       <= pin_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
        end
    end

    assign Pin_Out       = pin_q;
    assign Press_Pulse   = press_q;
    assign Release_Pulse = release_q;
    assign Long_Pulse    = long_q;

    a_pulse_excl: assert property (@(posedge CLK) !(Press_Pulse && Release_Pulse));

endmodule

// File: tb/tb_key_debounce_fsm.sv
// Bench for key_debounce_fsm: deadline-based reference model, directed scenarios,
// then randomized strobes and resets.
module tb_key_debounce_fsm;

    localparam int unsigned T1MS        = 3;
    localparam int unsigned DEBOUNCE_MS = 2;
    localparam int unsigned LONG_MS     = 5;
    localparam int          LAT         = DEBOUNCE_MS * (T1MS + 1) + 1;  // 9
    localparam int          LONG_LAT    = LONG_MS * (T1MS + 1) + 1;      // 21

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic h2l = 1'b0;
    logic l2h = 1'b0;
    logic pin_out, press_pulse, release_pulse, long_pulse;

    key_debounce_fsm #(
        .T1MS        (T1MS),
        .DEBOUNCE_MS (DEBOUNCE_MS),
        .LONG_MS     (LONG_MS)
    ) dut (
        .CLK           (clk),
        .RST           (rst),
        .H2L_Sig       (h2l),
        .L2H_Sig       (l2h),
        .Pin_Out       (pin_out),
        .Press_Pulse   (press_pulse),
        .Release_Pulse (release_pulse),
        .Long_Pulse    (long_pulse)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int edge_n   = 0;

    // Reference model: level plus pending deadlines, in absolute edge numbers
    bit m_pin = 1'b1;
    bit m_press, m_rel, m_long;
    int m_deadline = -1;
    int m_long_at  = -1;

    int press_edge = -1, rel_edge = -1, long_edge = -1;
    int press_cnt = 0, rel_cnt = 0, long_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s edge=%0d actual=%0d expected=%0d", name, edge_n, act, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit h, input bit l);
        m_press = 1'b0;
        m_rel   = 1'b0;
        m_long  = 1'b0;
        if (r) begin
            m_pin      = 1'b1;
            m_deadline = -1;
            m_long_at  = -1;
        end else if (m_deadline >= 0) begin
            if (edge_n == m_deadline) begin
                m_pin      = !m_pin;
                m_deadline = -1;
                if (!m_pin) begin
                    m_press   = 1'b1;
                    m_long_at = edge_n + LONG_LAT;
                end else begin
                    m_rel = 1'b1;
                end
            end
        end else if (m_pin) begin
            if (h) m_deadline = edge_n + LAT;
        end else begin
            if (edge_n == m_long_at) begin
                m_long    = 1'b1;
                m_long_at = -1;
            end
            if (l) begin
                m_deadline = edge_n + LAT;
                m_long_at  = -1;
            end
        end
    endtask

    task automatic cycle(input bit r, input bit h, input bit l);
        @(negedge clk);
        rst = r;
        h2l = h;
        l2h = l;
        @(posedge clk);
        edge_n++;
        model_step(r, h, l);
        #1;
        check("pin_out", int'(pin_out), int'(m_pin));
        check("press_pulse", int'(press_pulse), int'(m_press));
        check("release_pulse", int'(release_pulse), int'(m_rel));
        check("long_pulse", int'(long_pulse), int'(m_long));
        if (press_pulse) begin press_edge = edge_n; press_cnt++; end
        if (release_pulse) begin rel_edge = edge_n; rel_cnt++; end
        if (long_pulse) begin long_edge = edge_n; long_cnt++; end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int h_edge, l_edge, base_cnt, base_rel, chg;
        bit prev;

        // Reset then idle
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        check("reset_pin", int'(pin_out), 1);
        check("reset_pulses", int'({press_pulse, release_pulse, long_pulse}), 0);
        chg  = 0;
        prev = pin_out;
        for (int i = 0; i < 100; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            if (pin_out != prev || press_pulse || release_pulse || long_pulse) chg++;
            prev = pin_out;
        end
        check("idle_stable", chg, 0);

        // Clean press, then long press
        cycle(1'b0, 1'b1, 1'b0);
        h_edge = edge_n;
        idle(15);
        check("press_latency", press_edge - h_edge, 9);
        check("press_level", int'(pin_out), 0);
        idle(130);
        check("long_count", long_cnt, 1);
        check("long_latency", long_edge - press_edge, 21);

        // Release
        cycle(1'b0, 1'b0, 1'b1);
        l_edge = edge_n;
        idle(15);
        check("release_latency", rel_edge - l_edge, 9);
        check("release_level", int'(pin_out), 1);

        // Bounce rejection
        base_rel = rel_cnt;
        cycle(1'b0, 1'b1, 1'b0);
        h_edge = edge_n;
        idle(2);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        idle(10);
        check("bounce_press_latency", press_edge - h_edge, 9);
        check("bounce_no_release", rel_cnt - base_rel, 0);
        cycle(1'b0, 1'b0, 1'b1);
        idle(12);

        // Mid-operation reset aborts the press delay
        base_cnt = press_cnt;
        cycle(1'b0, 1'b1, 1'b0);
        idle(4);
        cycle(1'b1, 1'b0, 1'b0);
        idle(12);
        check("reset_abort_press", press_cnt - base_cnt, 0);
        check("reset_abort_level", int'(pin_out), 1);
        cycle(1'b0, 1'b1, 1'b0);
        h_edge = edge_n;
        idle(12);
        check("restart_latency", press_edge - h_edge, 9);
        cycle(1'b0, 1'b0, 1'b1);
        idle(12);

        // Random strobes and occasional resets
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 299) == 0,
                  $urandom_range(0, 11) == 0,
                  $urandom_range(0, 11) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
